// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
//   Shared definitions for the iterative multiply/divide unit: data and op
//   widths, the E-stage op encodings, the sequencer state encodings and a
//   two's-complement helper.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int MD_OP_LENGTH = 3;
    localparam int CNT_WIDTH    = 5;

    localparam logic [WORD_WIDTH-1:0] ZEROWORD = '0;

    // Op encodings presented by the E stage.
    typedef enum logic [MD_OP_LENGTH-1:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Two's-complement negation of one word (modulo 2^32).
    function automatic logic [WORD_WIDTH-1:0] neg_word(input logic [WORD_WIDTH-1:0] v);
        return ZEROWORD - v;
    endfunction

    // Magnitude of a signed word; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [WORD_WIDTH-1:0] abs_word(input logic [WORD_WIDTH-1:0] v);
        return v[WORD_WIDTH-1] ? neg_word(v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit with architectural HI/LO registers, placed
//   beside the execute-stage ALU. Multiplies use a 64-bit {acc, multiplier}
//   shift-add; divides use restoring division. Both share one 33-bit
//   adder/subtractor. Each operation takes 32 CALC cycles plus one FIX cycle
//   in which signs are corrected and HI/LO are written.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (priority over flushE)
//   mdOpE     in   E-stage op (md_op_e encoding)
//   SrcA      in   multiplicand / dividend / MTHI-MTLO data
//   SrcB      in   multiplier / divisor
//   flushE    in   E-stage flush; aborts any operation, HI/LO unchanged
//   mdStallE  out  combinational stall request to the hazard unit
//   hiOut     out  HI register
//   loOut     out  LO register
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MD_OP_LENGTH-1:0] mdOpE,
    input  logic [WORD_WIDTH-1:0]   SrcA,
    input  logic [WORD_WIDTH-1:0]   SrcB,
    input  logic                    flushE,
    output logic                    mdStallE,
    output logic [WORD_WIDTH-1:0]   hiOut,
    output logic [WORD_WIDTH-1:0]   loOut
);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = '1;

    // Sequencer and architectural state.
    md_state_e                state_q,   state_d;
    logic [CNT_WIDTH-1:0]     cnt_q,     cnt_d;
    logic [WORD_WIDTH-1:0]    hi_q,      hi_d;
    logic [WORD_WIDTH-1:0]    lo_q,      lo_d;
    // acc: upper product half / partial remainder.
    // mlr: multiplier shifting out + product low bits in / dividend out + quotient in.
    // mcand: multiplicand / divisor magnitude.
    logic [WORD_WIDTH-1:0]    acc_q,     acc_d;
    logic [WORD_WIDTH-1:0]    mlr_q,     mlr_d;
    logic [WORD_WIDTH-1:0]    mcand_q,   mcand_d;
    logic                     is_div_q,  is_div_d;
    logic                     neg_res_q, neg_res_d;   // negate product / quotient
    logic                     neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)

    // Op decode.
    logic is_mul_op;
    logic is_div_op;
    logic is_signed_op;
    logic start_op;

    always_comb begin
        is_mul_op    = (mdOpE == MD_MULT) || (mdOpE == MD_MULTU);
        is_div_op    = (mdOpE == MD_DIV)  || (mdOpE == MD_DIVU);
        is_signed_op = (mdOpE == MD_MULT) || (mdOpE == MD_DIV);
        // A divide by zero is a no-op and never starts the sequencer.
        start_op     = is_mul_op || (is_div_op && (SrcB != ZEROWORD));
    end

    assign mdStallE = ((state_q == MD_IDLE) && start_op && !flushE) ||
                      (state_q == MD_CALC);

    // Shared 33-bit adder. Multiply adds the multiplicand to the zero-extended
    // accumulator; divide subtracts the divisor from the remainder shifted left
    // with the next dividend bit (a - b == a + ~b + 1).
    logic [WORD_WIDTH:0] add_a;
    logic [WORD_WIDTH:0] add_b;
    logic [WORD_WIDTH:0] add_sum;

    always_comb begin
        add_a   = is_div_q ? {acc_q, mlr_q[WORD_WIDTH-1]} : {1'b0, acc_q};
        add_b   = is_div_q ? ~{1'b0, mcand_q}             : {1'b0, mcand_q};
        add_sum = add_a + add_b + {{WORD_WIDTH{1'b0}}, is_div_q};
    end

    // Sign-corrected results used in FIX.
    logic [2*WORD_WIDTH-1:0] product;
    logic [2*WORD_WIDTH-1:0] product_fix;
    logic [WORD_WIDTH-1:0]   quot_fix;
    logic [WORD_WIDTH-1:0]   rem_fix;

    always_comb begin
        product     = {acc_q, mlr_q};
        product_fix = neg_res_q ? ({(2*WORD_WIDTH){1'b0}} - product) : product;
        quot_fix    = neg_res_q ? neg_word(mlr_q) : mlr_q;
        rem_fix     = neg_rem_q ? neg_word(acc_q) : acc_q;
    end

    // Next-state logic.
    logic [WORD_WIDTH:0] mul_step;
    logic                quot_bit;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        mlr_d     = mlr_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mul_step  = {1'b0, acc_q};
        quot_bit  = 1'b0;

        if (flushE) begin
            // Abort whatever is in flight; in IDLE this also drops MTHI/MTLO
            // writes and operation starts.
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (start_op) begin
                        state_d   = MD_CALC;
                        cnt_d     = '0;
                        acc_d     = ZEROWORD;
                        is_div_d  = is_div_op;
                        mlr_d     = is_signed_op ? abs_word(SrcA) : SrcA;
                        mcand_d   = is_signed_op ? abs_word(SrcB) : SrcB;
                        neg_res_d = is_signed_op &&
                                    (SrcA[WORD_WIDTH-1] ^ SrcB[WORD_WIDTH-1]);
                        neg_rem_d = is_signed_op && is_div_op && SrcA[WORD_WIDTH-1];
                    end else if (mdOpE == MD_MTHI) begin
                        hi_d = SrcA;
                    end else if (mdOpE == MD_MTLO) begin
                        lo_d = SrcA;
                    end
                end

                MD_CALC: begin
                    if (is_div_q) begin
                        // No borrow out of bit 32 means the shifted remainder
                        // is at least the divisor: keep the difference.
                        quot_bit = ~add_sum[WORD_WIDTH];
                        acc_d    = quot_bit ? add_sum[WORD_WIDTH-1:0]
                                            : add_a[WORD_WIDTH-1:0];
                        mlr_d    = {mlr_q[WORD_WIDTH-2:0], quot_bit};
                    end else begin
                        mul_step = mlr_q[0] ? add_sum : {1'b0, acc_q};
                        acc_d    = mul_step[WORD_WIDTH:1];
                        mlr_d    = {mul_step[0], mlr_q[WORD_WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = MD_FIX;
                    end
                end

                MD_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = product_fix[2*WORD_WIDTH-1:WORD_WIDTH];
                        lo_d = product_fix[WORD_WIDTH-1:0];
                    end
                    state_d = MD_IDLE;
                end

                default: state_d = MD_IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= ZEROWORD;
            lo_q      <= ZEROWORD;
            acc_q     <= ZEROWORD;
            mlr_q     <= ZEROWORD;
            mcand_q   <= ZEROWORD;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            mlr_q     <= mlr_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign hiOut = hi_q;
    assign loOut = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit. Completed operations are pushed into a
//   scoreboard queue at issue; a monitor detects completion from the stall
//   profile (a run of stall cycles followed by the FIX cycle) and compares
//   HI/LO and the stall length one cycle later. Register writes, divide by
//   zero and abort cases are checked inline.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [MD_OP_LENGTH-1:0] mdOpE;
    logic [WORD_WIDTH-1:0]   SrcA;
    logic [WORD_WIDTH-1:0]   SrcB;
    logic                    flushE;
    logic                    mdStallE;
    logic [WORD_WIDTH-1:0]   hiOut;
    logic [WORD_WIDTH-1:0]   loOut;

    mult_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .mdOpE    (mdOpE),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .flushE   (flushE),
        .mdStallE (mdStallE),
        .hiOut    (hiOut),
        .loOut    (loOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WORD_WIDTH-1:0] hi;
        logic [WORD_WIDTH-1:0] lo;
        int                    id;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after each falling edge, after the
    // stimulus has settled its inputs for the cycle.
    int   run_len  = 0;
    int   done_len = 0;
    logic prev_stall = 1'b0;
    logic pending    = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (pending) begin
                pending = 1'b0;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("op%0d_hi", e.id), hiOut, e.hi);
                    check($sformatf("op%0d_lo", e.id), loOut, e.lo);
                    check($sformatf("op%0d_stall_len", e.id), done_len, 33);
                end
            end
            if (mdStallE) begin
                run_len++;
            end else begin
                if (prev_stall) begin
                    pending  = 1'b1;
                    done_len = run_len;
                end
                run_len = 0;
            end
            prev_stall = mdStallE;
        end
    end

    // Issue one multi-cycle op (called at a falling edge), hold it while the
    // pipeline is stalled and through FIX, then return at the falling edge of
    // the first cycle after FIX with NOP presented.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int id);
        logic done;
        sb.push_back('{hi: exp_hi, lo: exp_lo, id: id});
        mdOpE = op;
        SrcA  = a;
        SrcB  = b;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!mdStallE) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL op%0d_timeout: stall still high after 40 cycles", id);
        end
        @(negedge clk);
        mdOpE = MD_NOP;
    endtask

    initial begin
        rst    = 1'b1;
        mdOpE  = MD_NOP;
        SrcA   = '0;
        SrcB   = '0;
        flushE = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", hiOut, 32'h0);
        check("reset_lo", loOut, 32'h0);
        check("reset_stall", {31'b0, mdStallE}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Multiplies (the second pair back-to-back).
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        do_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2);
        do_op(MD_MULTU, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 3);

        // Divides: HI = remainder, LO = quotient.
        do_op(MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4);
        do_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5);
        do_op(MD_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 6);
        do_op(MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 7);

        // Load HI/LO, then divide by zero must leave them alone and never stall.
        mdOpE = MD_MTHI; SrcA = 32'hAAAA_5555;
        #1 check("mthi_stall", {31'b0, mdStallE}, 32'h0);
        @(negedge clk);
        mdOpE = MD_MTLO; SrcA = 32'hAAAA_5555;
        #1 check("mtlo_stall", {31'b0, mdStallE}, 32'h0);
        @(negedge clk);
        mdOpE = MD_DIVU; SrcA = 32'h0000_0005; SrcB = 32'h0;
        #1 check("divu0_stall0", {31'b0, mdStallE}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check($sformatf("divu0_stall%0d", i + 1), {31'b0, mdStallE}, 32'h0);
        end
        check("divu0_hi", hiOut, 32'hAAAA_5555);
        check("divu0_lo", loOut, 32'hAAAA_5555);

        // MTHI then MTLO in consecutive cycles.
        @(negedge clk);
        mdOpE = MD_MTHI; SrcA = 32'h0000_1234;
        #1 check("mthi2_stall", {31'b0, mdStallE}, 32'h0);
        @(negedge clk);
        mdOpE = MD_MTLO; SrcA = 32'h0000_5678;
        #1 check("mthi2_hi_next", hiOut, 32'h0000_1234);
        check("mthi2_lo_old", loOut, 32'hAAAA_5555);
        @(negedge clk);
        mdOpE = MD_NOP;
        #1 check("mtlo2_lo_next", loOut, 32'h0000_5678);
        check("mtlo2_hi_keep", hiOut, 32'h0000_1234);

        // Flush in IDLE suppresses both the register write and a start.
        @(negedge clk);
        mdOpE = MD_MTHI; SrcA = 32'h0000_DEAD; flushE = 1'b1;
        #1 check("flush_idle_stall", {31'b0, mdStallE}, 32'h0);
        @(negedge clk);
        mdOpE = MD_MULT; SrcA = 32'h3; SrcB = 32'h4;
        #1 check("flush_mthi_hi", hiOut, 32'h0000_1234);
        check("flush_start_stall", {31'b0, mdStallE}, 32'h0);
        @(negedge clk);
        flushE = 1'b0; mdOpE = MD_NOP;
        #1 check("flush_start_nostart", {31'b0, mdStallE}, 32'h0);

        // Abort MULT 3x4 with flushE in CALC iteration 10 (cycle T+11).
        @(negedge clk);
        mdOpE = MD_MULT; SrcA = 32'h3; SrcB = 32'h4;
        repeat (11) @(negedge clk);
        flushE = 1'b1;
        #1 check("flush_calc_stall", {31'b0, mdStallE}, 32'h1);
        @(negedge clk);
        flushE = 1'b0; mdOpE = MD_NOP;
        #1 check("flush_abort_stall", {31'b0, mdStallE}, 32'h0);
        check("flush_abort_hi", hiOut, 32'h0000_1234);
        check("flush_abort_lo", loOut, 32'h0000_5678);
        repeat (2) @(negedge clk);
        #1 check("flush_abort_lo_late", loOut, 32'h0000_5678);

        // Abort MULT 3x4 with rst in CALC iteration 10.
        @(negedge clk);
        mdOpE = MD_MULT; SrcA = 32'h3; SrcB = 32'h4;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mdOpE = MD_NOP;
        #1 check("rst_abort_stall", {31'b0, mdStallE}, 32'h0);
        check("rst_abort_hi", hiOut, 32'h0);
        check("rst_abort_lo", loOut, 32'h0);
        repeat (2) @(negedge clk);
        #1 check("rst_abort_lo_late", loOut, 32'h0);

        // Sequencer must be back in IDLE and fully usable.
        @(negedge clk);
        do_op(MD_MULTU, 32'h3, 32'h4, 32'h0, 32'h0000_000C, 8);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
